sonic_rx_dma_sched: RTL

- Read-side scheduler for the SONIC RX circular buffer.
- Compares the clock-crossed RX write pointer with its own read pointer and issues fixed-length read bursts (rdreq + rd_address) into the buffer.
- Delays rdreq to mark returning data valid for the DMA engine, coalesces burst-complete interrupts, and flags overrun.
- Sits between the RX circular-buffer control wrapper and the PCIe DMA/IRQ logic, entirely in the read clock domain.

---
 rtl/sonic_rx_sched_pkg.sv | 7 +
 rtl/sonic_valid_delay.sv | 16 +
 rtl/sonic_rx_dma_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/sonic_rx_sched_pkg.sv
// sonic_rx_sched_pkg: shared FSM state type and ring-distance helper for the SONIC RX read scheduler
package sonic_rx_sched_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  function automatic logic [31:0] ring_dist(input logic [31:0] w, input logic [31:0] r, input int unsigned width);
    return (w - r) & ((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/sonic_valid_delay.sv
// sonic_valid_delay: fixed-latency valid shift register (req delayed by LAT cycles)
// Ports: clk, rst_n (async active-low), req in, valid out.
module sonic_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic valid
);
  logic [LAT-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= (sr << 1) | LAT'(req);
  assign valid = sr[LAT-1];
endmodule

// File: rtl/sonic_rx_dma_sched.sv
// sonic_rx_dma_sched: RX ring read scheduler issuing fixed bursts, valid delay, irq coalescing, overrun flag
// Ports: rd_clock/reset_n; enable, rx_ring_wptr, dma_ready, overrun_clr in;
//        rdreq, rd_address, dma_valid, burst_done, burst_len_out, irq, rx_ring_rptr, overrun out.
// Optional partial-burst flush on idle timeout: define SONIC_RX_SCHED_TIMEOUT_EN.
module sonic_rx_dma_sched
  import sonic_rx_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int BURST_LEN      = 16,
  parameter int RD_LATENCY     = 2,
  parameter int IRQ_COALESCE   = 4,
  parameter int OVR_MARGIN     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  rd_clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] rx_ring_wptr,
  input  logic                  dma_ready,
  output logic                  rdreq,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  dma_valid,
  output logic                  burst_done,
  output logic [ADDR_WIDTH:0]   burst_len_out,
  output logic                  irq,
  output logic [ADDR_WIDTH-1:0] rx_ring_rptr,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam int LW = ADDR_WIDTH + 1;
  state_t state;
  logic [ADDR_WIDTH-1:0] rptr, avail;
  logic [LW-1:0] len, remaining;
  logic [15:0] icnt;
  logic last, full_go, ovr_set, partial;
  assign avail      = ADDR_WIDTH'(ring_dist(32'(rx_ring_wptr), 32'(rptr), ADDR_WIDTH));
  assign rdreq      = state == BURST && dma_ready;
  assign rd_address = rptr;
  assign rx_ring_rptr = rptr;
  assign last       = rdreq && remaining == LW'(1);
  assign full_go    = enable && dma_ready && 32'(avail) >= 32'(BURST_LEN);
  assign ovr_set    = 32'(avail) >= (32'd1 << ADDR_WIDTH) - 32'(OVR_MARGIN);
`ifdef SONIC_RX_SCHED_TIMEOUT_EN
  logic [15:0] timer;
  logic timing;
  assign timing  = state == IDLE && enable && avail != '0 && 32'(avail) < 32'(BURST_LEN);
  assign partial = timing && dma_ready && timer == 16'(TIMEOUT_CYCLES - 1);
  // Timer parks at the threshold until the DMA engine is ready to take the flush.
  always_ff @(posedge rd_clock or negedge reset_n)
    if (!reset_n) timer <= '0;
    else timer <= (!timing || partial) ? '0 : timer == 16'(TIMEOUT_CYCLES - 1) ? timer : timer + 16'd1;
`else
  logic unused_timeout;
  assign partial = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif
  always_ff @(posedge rd_clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rptr          <= '0;
      len           <= '0;
      remaining     <= '0;
      icnt          <= '0;
      burst_done    <= 1'b0;
      burst_len_out <= '0;
      irq           <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // DONE outputs are registered on the last issue, so they coincide with the DONE cycle.
      burst_done    <= last;
      burst_len_out <= last ? len : '0;
      irq           <= last && icnt == 16'(IRQ_COALESCE - 1);
      if (last) icnt <= icnt == 16'(IRQ_COALESCE - 1) ? '0 : icnt + 16'd1;
      overrun <= ovr_set || (overrun && !overrun_clr);
      if (rdreq) begin
        rptr      <= rptr + ADDR_WIDTH'(1);
        remaining <= remaining - LW'(1);
      end
      case (state)
        IDLE: if (full_go || partial) begin
          state     <= BURST;
          len       <= full_go ? LW'(BURST_LEN) : LW'(avail);
          remaining <= full_go ? LW'(BURST_LEN) : LW'(avail);
        end
        BURST: if (last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  sonic_valid_delay #(.LAT(RD_LATENCY)) u_delay (
    .clk(rd_clock),
    .rst_n(reset_n),
    .req(rdreq),
    .valid(dma_valid)
  );
endmodule
